// File: rtl/ddr_chip_cmd_tracker.sv
// DDR chip command front end: per-bank state machines, core timing enforcement and
// CL-delayed read/write burst window generation.
module ddr_chip_cmd_tracker #(
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned COLWIDTH  = 10,
  parameter int unsigned BL        = 8,
  parameter int unsigned CL        = 4,
  parameter int unsigned TRCD      = 3,
  parameter int unsigned TRAS      = 8,
  parameter int unsigned TRP       = 3,
  parameter int unsigned TRFC      = 20,
  parameter int unsigned TCCD_S    = 4,
  parameter int unsigned TCCD_L    = 6,
  localparam int unsigned BEATW    = (BL > 2) ? $clog2(BL / 2) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic [ADDRWIDTH-1:0] row,
  input  logic [COLWIDTH-1:0]  column,
  output logic                 cmd_ready,
  output logic                 cmd_ack,
  output logic                 cmd_err,
  output logic                 burst_active,
  output logic                 burst_rd,
  output logic [BGWIDTH-1:0]   burst_bg,
  output logic [BAWIDTH-1:0]   burst_ba,
  output logic [ADDRWIDTH-1:0] burst_row,
  output logic [COLWIDTH-1:0]  burst_col,
  output logic [BEATW-1:0]     burst_beat,
  input  logic [BGWIDTH-1:0]   q_bg,
  input  logic [BAWIDTH-1:0]   q_ba,
  output logic                 q_open,
  output logic [ADDRWIDTH-1:0] q_row
);

  localparam int unsigned NBW  = BGWIDTH + BAWIDTH;
  localparam int unsigned NB   = 2 ** NBW;
  localparam int unsigned NBG  = 2 ** BGWIDTH;
  localparam int unsigned CntW = $clog2(TRFC + TRAS + TRCD + TRP + TCCD_L + 2);
  // Counters hold "edges still to wait"; the command edge itself counts as the first.
  localparam int unsigned LdTrcd = (TRCD > 1) ? TRCD - 1 : 0;
  localparam int unsigned LdTras = (TRAS > 1) ? TRAS - 1 : 0;
  localparam int unsigned LdTrp  = (TRP > 1) ? TRP - 1 : 0;
  localparam int unsigned LdTrfc = (TRFC > 1) ? TRFC - 1 : 0;
  localparam int unsigned LdCcdS = (TCCD_S > 1) ? TCCD_S - 1 : 0;
  localparam int unsigned LdCcdL = (TCCD_L > 1) ? TCCD_L - 1 : 0;

  localparam logic [2:0] CmdNop = 3'd0, CmdAct = 3'd1, CmdRd = 3'd2, CmdWr = 3'd3,
                         CmdPre = 3'd4, CmdPrea = 3'd5, CmdRef = 3'd6;

  typedef enum logic [2:0] {
    StIdle, StActivating, StActive, StPrecharging, StRefreshing
  } bank_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 rd;
    logic [BGWIDTH-1:0]   bg;
    logic [BAWIDTH-1:0]   ba;
    logic [ADDRWIDTH-1:0] row;
    logic [COLWIDTH-1:0]  col;
  } pipe_t;

  bank_state_e          bank_state_q [NB];
  bank_state_e          bank_state_d [NB];
  logic [CntW-1:0]      timer_q [NB];
  logic [CntW-1:0]      timer_d [NB];
  logic [CntW-1:0]      tras_q [NB];
  logic [CntW-1:0]      tras_d [NB];
  logic [ADDRWIDTH-1:0] open_row_q [NB];
  logic [ADDRWIDTH-1:0] open_row_d [NB];
  logic [CntW-1:0]      ccd_q [NBG];
  logic [CntW-1:0]      ccd_d [NBG];
  logic [CntW-1:0]      ref_cnt_q, ref_cnt_d;
  pipe_t                pipe_q [CL];
  pipe_t                pipe_d [CL];
  pipe_t                burst_q, burst_d;
  logic                 active_q, active_d;
  logic [BEATW-1:0]     beat_q, beat_d;
  logic                 ack_q, err_q;

  logic [NBW-1:0] sel;
  logic           all_idle, all_pre_ok, legal, accept, reject;

  function automatic logic [CntW-1:0] dec(input logic [CntW-1:0] v);
    return (v == '0) ? v : v - CntW'(1);
  endfunction

  function automatic logic [CntW-1:0] max_cnt(input logic [CntW-1:0] a,
                                              input logic [CntW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign sel       = {bg, ba};
  assign cmd_ready = !halt;

  always_comb begin
    all_idle   = 1'b1;
    all_pre_ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (bank_state_q[i] != StIdle) all_idle = 1'b0;
      if (!(bank_state_q[i] == StIdle ||
            (bank_state_q[i] == StActive && tras_q[i] == '0))) all_pre_ok = 1'b0;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (cmd)
      CmdNop:       legal = 1'b1;
      CmdAct:       legal = (bank_state_q[sel] == StIdle) && (ref_cnt_q == '0);
      CmdRd, CmdWr: legal = (bank_state_q[sel] == StActive) && (ccd_q[bg] == '0);
      CmdPre:       legal = (bank_state_q[sel] == StIdle) ||
                            (bank_state_q[sel] == StActive && tras_q[sel] == '0);
      CmdPrea:      legal = all_pre_ok;
      CmdRef:       legal = all_idle;
      default:      legal = 1'b0;
    endcase
  end

  assign accept = cmd_valid && !halt && legal;
  assign reject = cmd_valid && !halt && !legal;

  always_comb begin
    bank_state_d = bank_state_q;
    open_row_d   = open_row_q;
    ref_cnt_d    = dec(ref_cnt_q);
    for (int i = 0; i < NB; i++) begin
      timer_d[i] = dec(timer_q[i]);
      tras_d[i]  = dec(tras_q[i]);
      case (bank_state_q[i])
        StActivating:  if (timer_q[i] <= CntW'(1)) bank_state_d[i] = StActive;
        StPrecharging: if (timer_q[i] <= CntW'(1)) bank_state_d[i] = StIdle;
        StRefreshing:  if (ref_cnt_q <= CntW'(1)) bank_state_d[i] = StIdle;
        default: ;
      endcase
    end
    for (int g = 0; g < NBG; g++) ccd_d[g] = dec(ccd_q[g]);
    pipe_d[0] = '0;
    for (int k = 1; k < CL; k++) pipe_d[k] = pipe_q[k-1];

    if (accept) begin
      case (cmd)
        CmdAct: begin
          bank_state_d[sel] = (TRCD > 1) ? StActivating : StActive;
          timer_d[sel]      = CntW'(LdTrcd);
          tras_d[sel]       = CntW'(LdTras);
          open_row_d[sel]   = row;
        end
        CmdRd, CmdWr: begin
          for (int g = 0; g < NBG; g++)
            ccd_d[g] = max_cnt(ccd_d[g], (BGWIDTH'(g) == bg) ? CntW'(LdCcdL) : CntW'(LdCcdS));
          pipe_d[0].valid = 1'b1;
          pipe_d[0].rd    = (cmd == CmdRd);
          pipe_d[0].bg    = bg;
          pipe_d[0].ba    = ba;
          pipe_d[0].row   = open_row_q[sel];
          pipe_d[0].col   = column;
        end
        CmdPre: begin
          if (bank_state_q[sel] == StActive) begin
            bank_state_d[sel] = (TRP > 1) ? StPrecharging : StIdle;
            timer_d[sel]      = CntW'(LdTrp);
          end
        end
        CmdPrea: begin
          for (int i = 0; i < NB; i++) begin
            if (bank_state_q[i] == StActive) begin
              bank_state_d[i] = (TRP > 1) ? StPrecharging : StIdle;
              timer_d[i]      = CntW'(LdTrp);
            end
          end
        end
        CmdRef: begin
          ref_cnt_d = CntW'(LdTrfc);
          for (int i = 0; i < NB; i++) bank_state_d[i] = (TRFC > 1) ? StRefreshing : StIdle;
        end
        default: ;
      endcase
    end
  end

  // A new window can only start once the previous one has ended (TCCD_S >= BL/2).
  always_comb begin
    burst_d  = burst_q;
    active_d = active_q;
    beat_d   = beat_q;
    if (pipe_q[CL-1].valid) begin
      burst_d  = pipe_q[CL-1];
      active_d = 1'b1;
      beat_d   = '0;
    end else if (active_q) begin
      if (beat_q == BEATW'(BL / 2 - 1)) begin
        active_d = 1'b0;
        beat_d   = '0;
      end else begin
        beat_d = beat_q + BEATW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        bank_state_q[i] <= StIdle;
        timer_q[i]      <= '0;
        tras_q[i]       <= '0;
        open_row_q[i]   <= '0;
      end
      for (int g = 0; g < NBG; g++) ccd_q[g] <= '0;
      for (int k = 0; k < CL; k++) pipe_q[k] <= '0;
      ref_cnt_q <= '0;
      burst_q   <= '0;
      active_q  <= 1'b0;
      beat_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= accept;
      err_q <= reject;
      if (!halt) begin
        bank_state_q <= bank_state_d;
        timer_q      <= timer_d;
        tras_q       <= tras_d;
        open_row_q   <= open_row_d;
        ccd_q        <= ccd_d;
        pipe_q       <= pipe_d;
        ref_cnt_q    <= ref_cnt_d;
        burst_q      <= burst_d;
        active_q     <= active_d;
        beat_q       <= beat_d;
      end
    end
  end

  assign cmd_ack      = ack_q;
  assign cmd_err      = err_q;
  assign burst_active = active_q;
  assign burst_rd     = burst_q.rd;
  assign burst_bg     = burst_q.bg;
  assign burst_ba     = burst_q.ba;
  assign burst_row    = burst_q.row;
  assign burst_col    = burst_q.col;
  assign burst_beat   = beat_q;
  assign q_open       = (bank_state_q[{q_bg, q_ba}] == StActive);
  assign q_row        = open_row_q[{q_bg, q_ba}];

endmodule

// File: tb/tb_ddr_chip_cmd_tracker.sv
// Bench for ddr_chip_cmd_tracker: directed timing scenarios plus random traffic, all
// checked against a time-stamp based model of the DDR command rules.
module tb_ddr_chip_cmd_tracker;

  localparam int BGW = 2, BAW = 2, AW = 17, CW = 10, BL = 8, CL = 4;
  localparam int TRCD = 3, TRAS = 8, TRP = 3, TRFC = 20, TCCD_S = 4, TCCD_L = 6;
  localparam int NBG = 4, NBA = 4, NB = 16, NBEAT = BL / 2;
  localparam longint Never = -100000;

  logic          clk = 1'b0, reset = 1'b1, halt = 1'b0, cmd_valid = 1'b0;
  logic [2:0]    cmd = '0;
  logic [BGW-1:0] bg = '0, q_bg = '0, burst_bg;
  logic [BAW-1:0] ba = '0, q_ba = '0, burst_ba;
  logic [AW-1:0] row = '0, burst_row, q_row;
  logic [CW-1:0] column = '0, burst_col;
  logic          cmd_ready, cmd_ack, cmd_err, burst_active, burst_rd, q_open;
  logic [1:0]    burst_beat;

  always #5 clk = ~clk;

  ddr_chip_cmd_tracker #(
    .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW), .BL(BL), .CL(CL),
    .TRCD(TRCD), .TRAS(TRAS), .TRP(TRP), .TRFC(TRFC), .TCCD_S(TCCD_S), .TCCD_L(TCCD_L)
  ) dut (
    .clk(clk), .reset(reset), .halt(halt), .cmd_valid(cmd_valid), .cmd(cmd), .bg(bg),
    .ba(ba), .row(row), .column(column), .cmd_ready(cmd_ready), .cmd_ack(cmd_ack),
    .cmd_err(cmd_err), .burst_active(burst_active), .burst_rd(burst_rd),
    .burst_bg(burst_bg), .burst_ba(burst_ba), .burst_row(burst_row),
    .burst_col(burst_col), .burst_beat(burst_beat), .q_bg(q_bg), .q_ba(q_ba),
    .q_open(q_open), .q_row(q_row)
  );

  int checks = 0, errors = 0;

  // Model: time stamps (in non-halted edges) of the last event per bank / bank group.
  longint t = 0;
  longint act_t [NB], pre_t [NB], col_t [NBG], ref_t;
  bit            open_m [NB];
  logic [AW-1:0] row_m [NB];
  typedef struct {
    longint start; bit rd; int g; int b; logic [AW-1:0] r; logic [CW-1:0] c;
  } win_t;
  win_t wins[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      act_t[i] = Never; pre_t[i] = Never; open_m[i] = 1'b0; row_m[i] = '0;
    end
    for (int g = 0; g < NBG; g++) col_t[g] = Never;
    ref_t = Never;
    wins.delete();
  endfunction

  function automatic bit idle_m(int i);
    return !open_m[i] && (t - pre_t[i] >= TRP) && (t - ref_t >= TRFC);
  endfunction

  function automatic bit active_m(int i);
    return open_m[i] && (t - act_t[i] >= TRCD);
  endfunction

  function automatic bit pre_ok_m(int i);
    return idle_m(i) || (open_m[i] && (t - act_t[i] >= TRAS));
  endfunction

  function automatic bit legal_m(int c, int g, int b);
    int i = g * NBA + b;
    bit ok;
    case (c)
      0: return 1'b1;
      1: return idle_m(i);
      2, 3: begin
        ok = active_m(i) && (t - col_t[g] >= TCCD_L);
        for (int o = 0; o < NBG; o++) if (o != g && t - col_t[o] < TCCD_S) ok = 1'b0;
        return ok;
      end
      4: return pre_ok_m(i);
      5: begin
        ok = 1'b1;
        for (int k = 0; k < NB; k++) if (!pre_ok_m(k)) ok = 1'b0;
        return ok;
      end
      6: begin
        ok = 1'b1;
        for (int k = 0; k < NB; k++) if (!idle_m(k)) ok = 1'b0;
        return ok;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic void apply_m(int c, int g, int b, logic [AW-1:0] r, logic [CW-1:0] col);
    int i = g * NBA + b;
    win_t w;
    case (c)
      1: begin open_m[i] = 1'b1; act_t[i] = t; row_m[i] = r; end
      2, 3: begin
        col_t[g] = t;
        w.start = t + CL; w.rd = (c == 2); w.g = g; w.b = b; w.r = row_m[i]; w.c = col;
        wins.push_back(w);
      end
      4: if (open_m[i]) begin open_m[i] = 1'b0; pre_t[i] = t; end
      5: for (int k = 0; k < NB; k++) if (open_m[k]) begin open_m[k] = 1'b0; pre_t[k] = t; end
      6: ref_t = t;
      default: ;
    endcase
  endfunction

  // One clock: drive at negedge, check every output #1 after the posedge.
  task automatic tick(input bit v, input int c, input int g, input int b,
                      input logic [AW-1:0] r, input logic [CW-1:0] col, input bit h);
    bit ea, ee, fnd;
    longint e;
    int qi;
    win_t w;
    @(negedge clk);
    halt = h; cmd_valid = v; cmd = 3'(c); bg = 2'(g); ba = 2'(b); row = r; column = col;
    q_bg = 2'($urandom()); q_ba = 2'($urandom());
    #1;
    check("cmd_ready", cmd_ready, !h);
    ea = 1'b0; ee = 1'b0;
    if (v && !h) begin
      if (legal_m(c, g, b)) begin ea = 1'b1; apply_m(c, g, b, r, col); end
      else ee = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!h) t++;
    check("cmd_ack", cmd_ack, ea);
    check("cmd_err", cmd_err, ee);
    e = t - 1;
    while (wins.size() > 0 && wins[0].start + NBEAT <= e) wins.delete(0);
    fnd = 1'b0;
    foreach (wins[k]) if (wins[k].start <= e && e < wins[k].start + NBEAT) begin
      fnd = 1'b1; w = wins[k];
    end
    check("burst_active", burst_active, fnd);
    if (fnd) begin
      check("burst_beat", burst_beat, e - w.start);
      check("burst_rd", burst_rd, w.rd);
      check("burst_bg", burst_bg, w.g);
      check("burst_ba", burst_ba, w.b);
      check("burst_row", burst_row, w.r);
      check("burst_col", burst_col, w.c);
    end
    qi = int'(q_bg) * NBA + int'(q_ba);
    check("q_open", q_open, active_m(qi));
    if (active_m(qi)) check("q_row", q_row, row_m[qi]);
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 0, 0, 0, '0, '0, 1'b0);
  endtask

  task automatic issue(input int c, input int g, input int b, input logic [AW-1:0] r);
    tick(1'b1, c, g, b, r, 10'(c * 37 + g), 1'b0);
  endtask

  // Reset released with halt high so no unmodelled edge runs before the next tick.
  task automatic apply_reset();
    reset = 1'b1; halt = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("rst_ready", cmd_ready, 1);
    check("rst_ack", cmd_ack, 0);
    check("rst_err", cmd_err, 0);
    check("rst_burst", burst_active, 0);
    check("rst_beat", burst_beat, 0);
    check("rst_q_open", q_open, 0);
    @(negedge clk);
    halt = 1'b1;
    reset = 1'b0;
  endtask

  initial begin
    int rr, c;
    apply_reset();

    // ACT -> RD spacing and burst timing.
    issue(1, 1, 2, 17'h1ABCD);
    check("act_ack", cmd_ack, 1);
    nop(1);
    issue(2, 1, 2, '0);
    check("rd_early", cmd_err, 1);
    issue(2, 1, 2, '0);
    check("rd_ok", cmd_ack, 1);
    for (int k = 1; k <= 8; k++) begin
      nop(1);
      check("win_active", burst_active, (k >= 4 && k <= 7));
      if (k >= 4 && k <= 7) begin
        check("win_beat", burst_beat, k - 4);
        check("win_row", burst_row, 17'h1ABCD);
      end
    end

    // tRAS then tRP.
    issue(1, 2, 0, 17'h00123);
    nop(6);
    issue(4, 2, 0, '0);
    check("pre_early", cmd_err, 1);
    issue(4, 2, 0, '0);
    check("pre_ok", cmd_ack, 1);
    nop(1);
    issue(1, 2, 0, 17'h00456);
    check("act_trp_early", cmd_err, 1);
    issue(1, 2, 0, 17'h00456);
    check("act_trp_ok", cmd_ack, 1);

    // Halt during tRCD and mid-burst.
    issue(1, 3, 1, 17'h0F0F0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 2, 3, 1, '0, '0, 1'b1);
      check("halt_no_ack", cmd_ack | cmd_err, 0);
    end
    nop(2);
    issue(3, 3, 1, '0);
    check("rd_after_halt", cmd_ack, 1);
    nop(5);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 0, 0, 0, '0, '0, 1'b1);
      check("halt_beat", burst_beat, 1);
      check("halt_active", burst_active, 1);
    end
    nop(1);
    check("resume_beat2", burst_beat, 2);
    nop(1);
    check("resume_beat3", burst_beat, 3);
    nop(1);
    check("resume_end", burst_active, 0);

    // REF / PREA / tRFC.
    nop(10);
    issue(6, 0, 0, '0);
    check("ref_open", cmd_err, 1);
    issue(5, 0, 0, '0);
    check("prea_ok", cmd_ack, 1);
    nop(2);
    issue(6, 0, 0, '0);
    check("ref_ok", cmd_ack, 1);
    nop(18);
    issue(1, 0, 0, 17'h00011);
    check("act_trfc_early", cmd_err, 1);
    issue(1, 0, 0, 17'h00011);
    check("act_trfc_ok", cmd_ack, 1);

    // Column spacing: same group vs different group.
    issue(1, 0, 1, 17'h00022);
    issue(1, 1, 0, 17'h00033);
    nop(3);
    issue(2, 0, 0, '0);
    check("ccd_first", cmd_ack, 1);
    nop(3);
    issue(2, 0, 1, '0);
    check("ccd_l_early", cmd_err, 1);
    nop(1);
    issue(2, 0, 1, '0);
    check("ccd_l_ok", cmd_ack, 1);
    nop(3);
    issue(3, 1, 0, '0);
    check("ccd_s_ok", cmd_ack, 1);
    nop(10);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rr = $urandom_range(99);
      c = (rr < 28) ? 1 : (rr < 58) ? 2 + $urandom_range(1) : (rr < 72) ? 4 :
          (rr < 76) ? 5 : (rr < 80) ? 6 : (rr < 95) ? 0 : 7;
      tick(($urandom_range(9) != 0), c, $urandom_range(3), $urandom_range(1),
           AW'($urandom()), CW'($urandom()), ($urandom_range(11) == 0));
    end

    // Reset mid-burst with three banks open.
    apply_reset();
    issue(1, 0, 0, 17'h00AAA);
    issue(1, 0, 1, 17'h00BBB);
    issue(1, 1, 0, 17'h00CCC);
    nop(3);
    issue(2, 0, 0, '0);
    nop(5);
    check("pre_rst_burst", burst_active, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_burst", burst_active, 0);
    for (int i = 0; i < NB; i++) begin
      q_bg = 2'(i / NBA); q_ba = 2'(i % NBA);
      #1;
      check("midrst_q_open", q_open, 0);
    end
    model_reset();
    @(negedge clk);
    halt = 1'b1;
    reset = 1'b0;
    issue(1, 0, 0, 17'h00DDD);
    check("act_after_rst", cmd_ack, 1);
    nop(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_chip_cmd_tracker.md
Name: ddr_chip_cmd_tracker

Overview:
- Chip-level command front end for the DDR emulation model; supersedes the plain bank-group fan-out with real per-bank state and timing enforcement.
- Parametrised in bank-group count, banks per group, row and column widths, burst length and all core timings.
- Accepts one DDR command per cycle, checks it against per-bank FSMs and timing counters, and rejects illegal or too-early commands.
- Emits a read/write burst window CL cycles after each accepted column command. Sits between the command generator and the bank-group storage arrays.

Parameters:
- BGWIDTH, 2, bank-group address bits; BANKGROUPS = 2**BGWIDTH
- BAWIDTH, 2, bank address bits; BANKSPERGROUP = 2**BAWIDTH
- ADDRWIDTH, 17, row address bits
- COLWIDTH, 10, column address bits
- BL, 8, burst length; burst window lasts BL/2 cycles
- CL, 4, cycles from accepted RD/WR to first burst cycle (>=1)
- TRCD, 3, ACT to RD/WR, same bank
- TRAS, 8, ACT to PRE, same bank
- TRP, 3, PRE to ACT, same bank
- TRFC, 20, REF to any ACT
- TCCD_S, 4, column to column, different bank group (>= BL/2)
- TCCD_L, 6, column to column, same bank group (>= TCCD_S)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- halt  in  1  freezes all state, counters and the pipeline
- cmd_valid  in  1  command present
- cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 reserved
- bg  in  BGWIDTH  bank group
- ba  in  BAWIDTH  bank
- row  in  ADDRWIDTH  row for ACT
- column  in  COLWIDTH  column for RD/WR
- cmd_ready  out  1  equals !halt
- cmd_ack  out  1  one-cycle pulse: command accepted
- cmd_err  out  1  one-cycle pulse: command rejected
- burst_active  out  1  burst window in progress
- burst_rd  out  1  1 read, 0 write
- burst_bg, burst_ba, burst_row, burst_col  out  widths as inputs  burst address
- burst_beat  out  clog2(BL/2)  cycle index within the window
- q_bg, q_ba  in  BGWIDTH/BAWIDTH  status query address
- q_open  out  1  queried bank ACTIVE (combinational)
- q_row  out  ADDRWIDTH  queried bank's open row (combinational)

Behaviour:
- Reset: all banks IDLE, all counters 0, pipeline empty. All outputs 0 except cmd_ready = !halt.
- Per-bank FSM states: IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING.
- Each bank holds open_row, a tRCD/tRP countdown and a tRAS countdown.
- ACT is legal only if the bank is IDLE and the chip REF counter is 0. Bank goes to ACTIVATING, loads TRCD and TRAS, latches row. ACTIVATING moves to ACTIVE when its counter reaches 0.
- RD/WR is legal only if the bank is ACTIVE and the column spacing counter for that bg is 0.
  - Accept reloads that bg's spacing counter with TCCD_L and every other bg's with TCCD_S; a counter is never lowered.
  - The command enters a CL-deep delay line carrying {rd, bg, ba, open_row, column}.
- PRE is legal if the bank is ACTIVE and its tRAS counter is 0 (go to PRECHARGING, load TRP), or if the bank is IDLE (no-op accept). PRECHARGING moves to IDLE at counter 0.
- PREA is legal only if every bank is IDLE or PRE-legal; then it precharges all ACTIVE banks, otherwise it rejects with no change.
- REF is legal only if all banks are IDLE. It loads the chip TRFC counter and marks all banks REFRESHING; they return to IDLE at 0.
- NOP and cmd 7: NOP accepts with no effect; cmd 7 always rejects.
- The accept/reject decision is combinational on the inputs. cmd_ack or cmd_err is registered and pulses in the cycle after cmd_valid && cmd_ready. A rejected command changes no state.
- Burst window:
  - When an entry leaves the delay line, burst_active goes high for BL/2 cycles; burst_beat counts 0..BL/2-1 and the address outputs are held.
  - Because TCCD_S >= BL/2, a new window starts at the earliest on the cycle after the previous one ends, so back-to-back windows are contiguous.
- Counters count down to 0 and saturate there; they never wrap.
- Halt:
  - cmd_ready is 0 and commands are ignored (neither ack nor err).
  - All counters, FSMs, the delay line and the burst beat freeze, and outputs hold.
  - On release, operation resumes exactly where it stopped.
- Reset asserted mid-burst or mid-timing clears everything immediately; no partial burst completes.
- Simultaneous events:
  - A counter expiring in the same cycle as a new command: the command sees the pre-expiry state and is rejected.
  - A query on a bank being activated this cycle returns the old status.

Test Plan:
- ACT bg1 ba2 row 0x1ABCD, then RD 2 cycles later -> RD cmd_err. RD at 3 cycles -> cmd_ack; burst_active rises 4 cycles after RD for 4 cycles, burst_row=0x1ABCD, burst_beat 0,1,2,3.
- Two banks open in bg0 and a third in bg1; RD bg0, then RD bg0 at +4 -> err; RD bg0 at +6 -> ack; RD bg1 at +4 -> ack with contiguous burst windows.
- PRE at 7 cycles after ACT -> err, at 8 -> ack; ACT same bank at PRE+2 -> err, at PRE+3 -> ack.
- REF with one bank ACTIVE -> err. PREA, then REF after TRP -> ack; ACT at REF+19 -> err, at REF+20 -> ack.
- halt high for 10 cycles during tRCD countdown and mid-burst -> no ack/err, burst_beat frozen; after release, RD is legal exactly TRCD active cycles after ACT and the burst finishes its remaining beats.
- reset pulsed mid-burst with 3 banks open -> burst_active 0 at once, q_open 0 for all banks, immediate ACT accepted.
